// File: rtl/segment_sequencer_pkg.sv
// Shared types and constants for the N-segment playback sequencer.
package segment_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_IMMEDIATE = 2'd0,
    MODE_AT_WRAP   = 2'd1,
    MODE_EXT_TRIG  = 2'd2
  } transition_mode_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_STOPPED = 2'd2
  } seq_state_t;

  // Repeat value meaning "loop forever"; sliced down to the instance width.
  localparam int unsigned REP_MAX_WIDTH = 64;
  localparam logic [REP_MAX_WIDTH-1:0] REP_INFINITE = '1;

  function automatic int unsigned seg_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/segment_index_counter.sv
// Divider, read index and loop counter for the active segment.
// Active settings are captured only on load; live inputs are otherwise ignored.
module segment_index_counter
  import segment_sequencer_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = 16,
  parameter int unsigned DIV_WIDTH = 32,
  parameter int unsigned REP_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [IDX_WIDTH-1:0] load_cycle,
  input  logic [DIV_WIDTH-1:0] load_div,
  input  logic [REP_WIDTH-1:0] load_rep,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 idx_strobe,
  output logic                 stop,
  output logic                 wrap_c
);

  logic [IDX_WIDTH-1:0] cycle_q, cycle_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [REP_WIDTH-1:0] rep_q, rep_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [REP_WIDTH-1:0] loop_q, loop_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 strobe_q, strobe_d;
  logic                 stop_q, stop_d;

  logic tc_c;
  logic last_c;
  logic rep_inf_c;

  assign tc_c      = (div_cnt_q == div_q - DIV_WIDTH'(1));
  assign last_c    = (idx_q == cycle_q);
  assign rep_inf_c = (rep_q == REP_INFINITE[REP_WIDTH-1:0]);
  assign wrap_c    = ~stop_q & tc_c & last_c;

  always_comb begin
    cycle_d   = cycle_q;
    div_d     = div_q;
    rep_d     = rep_q;
    div_cnt_d = div_cnt_q;
    loop_d    = loop_q;
    idx_d     = idx_q;
    strobe_d  = 1'b0;
    stop_d    = stop_q;
    if (load) begin
      cycle_d   = load_cycle;
      div_d     = (load_div == '0) ? DIV_WIDTH'(1) : load_div;
      rep_d     = load_rep;
      div_cnt_d = '0;
      loop_d    = '0;
      idx_d     = '0;
      strobe_d  = 1'b1;
      stop_d    = 1'b0;
    end else if (!stop_q) begin
      if (tc_c) begin
        div_cnt_d = '0;
        if (last_c) begin
          // Final loop ends by freezing on the last index rather than wrapping.
          if (!rep_inf_c && (loop_q == rep_q)) begin
            stop_d = 1'b1;
          end else begin
            idx_d    = '0;
            loop_d   = loop_q + REP_WIDTH'(1);
            strobe_d = 1'b1;
          end
        end else begin
          idx_d    = idx_q + IDX_WIDTH'(1);
          strobe_d = 1'b1;
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      div_q     <= DIV_WIDTH'(1);
      rep_q     <= REP_INFINITE[REP_WIDTH-1:0];
      div_cnt_q <= '0;
      loop_q    <= '0;
      idx_q     <= '0;
      strobe_q  <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      div_q     <= div_d;
      rep_q     <= rep_d;
      div_cnt_q <= div_cnt_d;
      loop_q    <= loop_d;
      idx_q     <= idx_d;
      strobe_q  <= strobe_d;
      stop_q    <= stop_d;
    end
  end

  assign idx        = idx_q;
  assign idx_strobe = strobe_q;
  assign stop       = stop_q;

endmodule

// File: rtl/segment_sequencer.sv
// N-segment playback sequencer: request FSM and per-segment settings mux.
// SEGMENT_SEQUENCER_EXT_TRIG_EN adds the TRIG port and the external-trigger mode.
module segment_sequencer
  import segment_sequencer_pkg::*;
#(
  parameter  int unsigned NUM_SEGMENTS = 2,
  parameter  int unsigned IDX_WIDTH    = 16,
  parameter  int unsigned DIV_WIDTH    = 32,
  parameter  int unsigned REP_WIDTH    = 32,
  localparam int unsigned SEG_W        = seg_width(NUM_SEGMENTS)
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              UPDATE,
  input  logic [SEG_W-1:0]                  REQ_SEGMENT,
  input  logic [1:0]                        TRANSITION_MODE,
  input  logic [NUM_SEGMENTS*IDX_WIDTH-1:0] CYCLE,
  input  logic [NUM_SEGMENTS*DIV_WIDTH-1:0] FREQ_DIV,
  input  logic [NUM_SEGMENTS*REP_WIDTH-1:0] REP,
`ifdef SEGMENT_SEQUENCER_EXT_TRIG_EN
  input  logic                              TRIG,
`endif
  output logic [IDX_WIDTH-1:0]              IDX,
  output logic                              IDX_STROBE,
  output logic [SEG_W-1:0]                  SEGMENT,
  output logic                              STOP,
  output logic                              BUSY
);

  seq_state_t       state_q, state_d;
  logic [SEG_W-1:0] pend_seg_q, pend_seg_d;
  transition_mode_t pend_mode_q, pend_mode_d;
  logic [SEG_W-1:0] segment_q, segment_d;
  logic             busy_q, busy_d;

  logic                 mode_ok_c;
  logic                 req_ok_c;
  logic                 load_c;
  logic [SEG_W-1:0]     tgt_seg_c;
  logic                 trig_rise_c;
  logic                 cnt_wrap_c;
  logic                 cnt_stop;
  logic [IDX_WIDTH-1:0] sel_cycle_c;
  logic [DIV_WIDTH-1:0] sel_div_c;
  logic [REP_WIDTH-1:0] sel_rep_c;

`ifdef SEGMENT_SEQUENCER_EXT_TRIG_EN
  logic [2:0] trig_sync_q, trig_sync_d;

  // Two stages of synchronisation plus one for edge detection.
  always_comb begin
    trig_sync_d = {trig_sync_q[1:0], TRIG};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) trig_sync_q <= '0;
    else     trig_sync_q <= trig_sync_d;
  end

  assign trig_rise_c = trig_sync_q[1] & ~trig_sync_q[2];
  assign mode_ok_c   = (TRANSITION_MODE != 2'd3);
`else
  assign trig_rise_c = 1'b0;
  assign mode_ok_c   = (TRANSITION_MODE == 2'(MODE_IMMEDIATE)) ||
                       (TRANSITION_MODE == 2'(MODE_AT_WRAP));
`endif

  assign req_ok_c = UPDATE & mode_ok_c & (32'(REQ_SEGMENT) < NUM_SEGMENTS);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_RUN;
      pend_seg_q  <= '0;
      pend_mode_q <= MODE_IMMEDIATE;
      segment_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_seg_q  <= pend_seg_d;
      pend_mode_q <= pend_mode_d;
      segment_q   <= segment_d;
      busy_q      <= busy_d;
    end
  end

  // Next state: a fresh request is judged on its own mode; AT_WRAP on a frozen
  // segment has no wrap to wait for, so it switches straight away.
  always_comb begin
    state_d     = state_q;
    pend_seg_d  = pend_seg_q;
    pend_mode_d = pend_mode_q;
    load_c      = 1'b0;
    tgt_seg_c   = pend_seg_q;
    if (req_ok_c) begin
      tgt_seg_c = REQ_SEGMENT;
      if ((TRANSITION_MODE == 2'(MODE_IMMEDIATE)) ||
          ((TRANSITION_MODE == 2'(MODE_AT_WRAP)) && cnt_stop)) begin
        load_c = 1'b1;
      end else begin
        state_d     = ST_PENDING;
        pend_seg_d  = REQ_SEGMENT;
        pend_mode_d = transition_mode_t'(TRANSITION_MODE);
      end
    end else if (state_q == ST_PENDING) begin
      if (((pend_mode_q == MODE_AT_WRAP) && cnt_wrap_c) ||
          ((pend_mode_q == MODE_EXT_TRIG) && trig_rise_c)) begin
        load_c = 1'b1;
      end
    end else if ((state_q == ST_RUN) && cnt_stop) begin
      state_d = ST_STOPPED;
    end
    if (load_c) state_d = ST_RUN;
  end

  // Registered outputs
  always_comb begin
    segment_d = segment_q;
    busy_d    = (state_d == ST_PENDING);
    if (load_c) segment_d = tgt_seg_c;
  end

  // Settings of the segment being switched to
  always_comb begin
    sel_cycle_c = '0;
    sel_div_c   = '0;
    sel_rep_c   = '0;
    for (int unsigned k = 0; k < NUM_SEGMENTS; k++) begin
      if (tgt_seg_c == SEG_W'(k)) begin
        sel_cycle_c = CYCLE[k*IDX_WIDTH +: IDX_WIDTH];
        sel_div_c   = FREQ_DIV[k*DIV_WIDTH +: DIV_WIDTH];
        sel_rep_c   = REP[k*REP_WIDTH +: REP_WIDTH];
      end
    end
  end

  segment_index_counter #(
    .IDX_WIDTH (IDX_WIDTH),
    .DIV_WIDTH (DIV_WIDTH),
    .REP_WIDTH (REP_WIDTH)
  ) u_counter (
    .clk        (CLK),
    .rst        (RST),
    .load       (load_c),
    .load_cycle (sel_cycle_c),
    .load_div   (sel_div_c),
    .load_rep   (sel_rep_c),
    .idx        (IDX),
    .idx_strobe (IDX_STROBE),
    .stop       (cnt_stop),
    .wrap_c     (cnt_wrap_c)
  );

  assign SEGMENT = segment_q;
  assign STOP    = cnt_stop;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_segment_sequencer.sv
// Bench for segment_sequencer: directed scenarios plus random requests,
// compared every cycle against an elapsed-time model of playback.
module tb_segment_sequencer;

  localparam int unsigned NSEG = 3;
  localparam int unsigned IW   = 8;
  localparam int unsigned DW   = 8;
  localparam int unsigned RW   = 8;
  localparam int unsigned SW   = 2;

  logic             CLK, RST, UPDATE;
  logic [SW-1:0]    REQ_SEGMENT;
  logic [1:0]       TRANSITION_MODE;
  logic [NSEG*IW-1:0] CYCLE;
  logic [NSEG*DW-1:0] FREQ_DIV;
  logic [NSEG*RW-1:0] REP;
  logic             TRIG;
  logic [IW-1:0]    IDX;
  logic             IDX_STROBE;
  logic [SW-1:0]    SEGMENT;
  logic             STOP, BUSY;

  int checks = 0;
  int errors = 0;

  segment_sequencer #(
    .NUM_SEGMENTS (NSEG), .IDX_WIDTH (IW), .DIV_WIDTH (DW), .REP_WIDTH (RW)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .UPDATE          (UPDATE),
    .REQ_SEGMENT     (REQ_SEGMENT),
    .TRANSITION_MODE (TRANSITION_MODE),
    .CYCLE           (CYCLE),
    .FREQ_DIV        (FREQ_DIV),
    .REP             (REP),
`ifdef SEGMENT_SEQUENCER_EXT_TRIG_EN
    .TRIG            (TRIG),
`endif
    .IDX             (IDX),
    .IDX_STROBE      (IDX_STROBE),
    .SEGMENT         (SEGMENT),
    .STOP            (STOP),
    .BUSY            (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef SEGMENT_SEQUENCER_EXT_TRIG_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  // Model: playback position is derived from clocks elapsed since the switch.
  int     m_seg, m_cyc, m_rep, m_pseg, m_pmode;
  longint m_div, m_e;
  bit     m_sb0, m_pend, m_t1, m_t2, m_t3;

  task automatic model_reset();
    m_seg = 0; m_cyc = 0; m_div = 1; m_rep = 255; m_e = 0; m_sb0 = 1'b0;
    m_pend = 1'b0; m_pseg = 0; m_pmode = 0; m_t1 = 0; m_t2 = 0; m_t3 = 0;
  endtask

  function automatic bit model_stopped();
    longint lim;
    lim = longint'(m_rep + 1) * longint'(m_cyc + 1) * m_div;
    return (m_rep != 255) && (m_e >= lim);
  endfunction

  function automatic logic [12:0] model_out();
    logic [IW-1:0] ix;
    bit sb, stp;
    stp = model_stopped();
    if (stp) ix = IW'(m_cyc);
    else     ix = IW'((m_e / m_div) % longint'(m_cyc + 1));
    if (m_e == 0) sb = m_sb0;
    else          sb = ((m_e % m_div) == 0) && !stp;
    return {ix, sb, SW'(m_seg), stp, m_pend};
  endfunction

  task automatic model_clock();
    bit valid, stp, wrap, rise, sw;
    int mode, req, nseg;
    longint fd;
    if (RST) begin model_reset(); return; end
    mode  = int'(TRANSITION_MODE);
    req   = int'(REQ_SEGMENT);
    valid = UPDATE && (req < NSEG) && (mode == 0 || mode == 1 || (EXT && mode == 2));
    stp   = model_stopped();
    wrap  = !stp && (((m_e + 1) % m_div) == 0) &&
            ((((m_e + 1) / m_div) % longint'(m_cyc + 1)) == 0);
    rise  = m_t2 && !m_t3;
    sw    = 1'b0;
    nseg  = m_pseg;
    if (valid) begin
      if (mode == 0 || (mode == 1 && stp)) begin sw = 1'b1; nseg = req; end
      else begin m_pend = 1'b1; m_pseg = req; m_pmode = mode; end
    end else if (m_pend) begin
      if ((m_pmode == 1 && wrap) || (m_pmode == 2 && rise)) sw = 1'b1;
    end
    if (sw) begin
      m_seg = nseg;
      m_cyc = int'(CYCLE[nseg*IW +: IW]);
      fd    = longint'(FREQ_DIV[nseg*DW +: DW]);
      m_div = (fd == 0) ? 1 : fd;
      m_rep = int'(REP[nseg*RW +: RW]);
      m_e   = 0; m_sb0 = 1'b1; m_pend = 1'b0;
    end else begin
      m_e++;
    end
    m_t3 = m_t2; m_t2 = m_t1; m_t1 = TRIG;
  endtask

  task automatic step();
    model_clock();
    @(posedge CLK);
    #1;
    UPDATE = 1'b0;
  endtask

  task automatic set_seg(input int k, input int c, input int d, input int r);
    CYCLE[k*IW +: IW]    = IW'(c);
    FREQ_DIV[k*DW +: DW] = DW'(d);
    REP[k*RW +: RW]      = RW'(r);
  endtask

  task automatic request(input int seg, input int mode);
    UPDATE = 1'b1; REQ_SEGMENT = SW'(seg); TRANSITION_MODE = 2'(mode);
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    RST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) RST = 1'b0;
      step();
      exp = model_out();
      checks++;
      if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== exp) begin
        errors++;
        $display("FAIL reset cyc%0d: got %h exp %h (idx,strb,seg,stop,busy)", i, {IDX, IDX_STROBE, SEGMENT, STOP, BUSY}, exp);
      end
    end
  endtask

  task automatic test_divider();
    logic [12:0] exp;
    set_seg(0, 3, 3, 255);
    request(0, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      exp = model_out();
      checks++;
      if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== exp) begin
        errors++;
        $display("FAIL divider cyc%0d: got %h exp %h", i, {IDX, IDX_STROBE, SEGMENT, STOP, BUSY}, exp);
      end
    end
  endtask

  task automatic test_repeat();
    logic [12:0] exp;
    set_seg(0, 2, 1, 1);
    request(0, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      exp = model_out();
      checks++;
      if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== exp) begin
        errors++;
        $display("FAIL repeat cyc%0d: got %h exp %h", i, {IDX, IDX_STROBE, SEGMENT, STOP, BUSY}, exp);
      end
    end
    checks++;
    if (STOP !== 1'b1 || IDX !== IW'(2) || IDX_STROBE !== 1'b0) begin
      errors++;
      $display("FAIL repeat_hold: got stop=%b idx=%0d strb=%b exp stop=1 idx=2 strb=0", STOP, IDX, IDX_STROBE);
    end
  endtask

  task automatic test_immediate();
    logic [12:0] exp;
    int n;
    set_seg(0, 7, 1, 255);
    set_seg(1, 4, 2, 255);
    request(0, 0);
    step();
    n = 0;
    while (IDX !== IW'(5) && n < 40) begin
      step();
      exp = model_out();
      checks++;
      if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== exp) begin
        errors++;
        $display("FAIL immediate_run: got %h exp %h", {IDX, IDX_STROBE, SEGMENT, STOP, BUSY}, exp);
      end
      n++;
    end
    checks++;
    if (IDX !== IW'(5)) begin
      errors++;
      $display("FAIL immediate_wait: idx %0d never reached 5", IDX);
    end
    request(1, 0);
    step();
    checks++;
    if (SEGMENT !== SW'(1) || IDX !== '0 || IDX_STROBE !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL immediate_switch: got seg=%0d idx=%0d strb=%b busy=%b exp 1 0 1 0", SEGMENT, IDX, IDX_STROBE, BUSY);
    end
  endtask

  task automatic test_at_wrap();
    logic [12:0] exp;
    int n;
    set_seg(0, 7, 1, 255);
    set_seg(1, 3, 1, 255);
    request(0, 0);
    step();
    step();
    request(1, 1);
    for (n = 0; n < 20; n++) begin
      if (n == 3) request(0, 1);
      step();
      exp = model_out();
      checks++;
      if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== exp) begin
        errors++;
        $display("FAIL at_wrap cyc%0d: got %h exp %h", n, {IDX, IDX_STROBE, SEGMENT, STOP, BUSY}, exp);
      end
    end
  endtask

  task automatic test_ignored();
    logic [12:0] exp;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) request(3, 0);
      if (i == 1) request(1, 3);
      if (i == 2) request(1, EXT ? 3 : 2);
      step();
      exp = model_out();
      checks++;
      if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== exp) begin
        errors++;
        $display("FAIL ignored case%0d: got %h exp %h", i, {IDX, IDX_STROBE, SEGMENT, STOP, BUSY}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp;
    set_seg(2, 5, 2, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) request(1, 0);
      if (i == 1) request(2, 0);
      if (i == 2) request(0, 1);
      if (i == 3) request(1, 0);
      step();
      exp = model_out();
      checks++;
      if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== exp) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %h exp %h", i, {IDX, IDX_STROBE, SEGMENT, STOP, BUSY}, exp);
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [12:0] exp;
    set_seg(0, 7, 2, 255);
    request(0, 0);
    step();
    request(1, 1);
    step();
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL rst_pend_busy: got %b exp 1", BUSY);
    end
    #1 RST = 1'b1;
    #1;
    checks++;
    if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== 13'd0) begin
      errors++;
      $display("FAIL rst_async: got %h exp 0", {IDX, IDX_STROBE, SEGMENT, STOP, BUSY});
    end
    model_reset();
    step();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      exp = model_out();
      checks++;
      if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== exp) begin
        errors++;
        $display("FAIL rst_after cyc%0d: got %h exp %h", i, {IDX, IDX_STROBE, SEGMENT, STOP, BUSY}, exp);
      end
    end
  endtask

  task automatic test_ext_trig();
    logic [12:0] exp;
    set_seg(0, 7, 1, 255);
    set_seg(1, 2, 1, 255);
    request(0, 0);
    for (int i = 0; i < 24; i++) begin
      if (i == 1 || i == 14) TRIG = 1'b1;
      if (i == 4 || i == 18) TRIG = 1'b0;
      if (i == 8) request(1, 2);
      step();
      exp = model_out();
      checks++;
      if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== exp) begin
        errors++;
        $display("FAIL ext_trig cyc%0d: got %h exp %h", i, {IDX, IDX_STROBE, SEGMENT, STOP, BUSY}, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] exp;
    int reps [4] = '{0, 1, 2, 255};
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0)
        set_seg(int'($urandom_range(0, NSEG - 1)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 3)), reps[$urandom_range(0, 3)]);
      if ($urandom_range(0, 7) == 0)
        request(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (EXT && $urandom_range(0, 5) == 0) TRIG = ~TRIG;
      step();
      exp = model_out();
      checks++;
      if ({IDX, IDX_STROBE, SEGMENT, STOP, BUSY} !== exp) begin
        errors++;
        $display("FAIL random cyc%0d: got %h exp %h", i, {IDX, IDX_STROBE, SEGMENT, STOP, BUSY}, exp);
      end
    end
  endtask

  initial begin
    RST = 1'b1; UPDATE = 1'b0; REQ_SEGMENT = '0; TRANSITION_MODE = '0; TRIG = 1'b0;
    CYCLE = '0; FREQ_DIV = '0; REP = '1;
    model_reset();
    #1;
    test_reset();
    test_divider();
    test_repeat();
    test_immediate();
    test_at_wrap();
    test_ignored();
    test_back_to_back();
    test_reset_pending();
    if (EXT) test_ext_trig();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/segment_sequencer.md
Name: segment_sequencer

Overview:
- Generalised N-segment playback sequencer for modulation/STM buffers. Replaces the fixed two-segment CYCLE_0/1, FREQ_DIV_0/1, REP_0/1 handling.
- Generates the read index for the active segment from its divider, cycle and repeat settings.
- Switches segments on a host UPDATE according to a selectable transition mode.
- Sits between the settings/controller block and the buffer read logic.

Parameters:
NUM_SEGMENTS, 2, number of segments (>=2); SEG_W = max(1, $clog2(NUM_SEGMENTS))
IDX_WIDTH, 16, index / cycle width
DIV_WIDTH, 32, frequency-divider width
REP_WIDTH, 32, repeat-count width

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
UPDATE  in  1  one-cycle pulse: new request valid
REQ_SEGMENT  in  SEG_W  requested segment
TRANSITION_MODE  in  2  0=IMMEDIATE, 1=AT_WRAP, 2=EXT_TRIG (macro only), 3=reserved
CYCLE  in  NUM_SEGMENTS*IDX_WIDTH  per-segment last index (length-1), segment k at [k*IDX_WIDTH +: IDX_WIDTH]
FREQ_DIV  in  NUM_SEGMENTS*DIV_WIDTH  per-segment clocks per index step
REP  in  NUM_SEGMENTS*REP_WIDTH  per-segment loops-1; all-ones = infinite
TRIG  in  1  external trigger (present only with SEGMENT_SEQUENCER_EXT_TRIG_EN)
IDX  out  IDX_WIDTH  current read index
IDX_STROBE  out  1  one-cycle pulse when IDX is loaded or changes
SEGMENT  out  SEG_W  active segment
STOP  out  1  repeat budget exhausted; IDX frozen
BUSY  out  1  request pending

Behaviour:
- Reset:
  - outputs: IDX=0, IDX_STROBE=0, SEGMENT=0, STOP=0, BUSY=0
  - active registers: cycle=0, div=1, rep=all-ones; divider count=0, loop count=0; state RUN
- Active settings:
  - CYCLE/FREQ_DIV/REP of the target segment are latched into active registers at switch time only.
  - Live input changes do not affect playback until the next switch.
- Divider:
  - counter runs 0..div-1; FREQ_DIV=0 is treated as 1.
  - On terminal count: IDX increments, IDX_STROBE=1 for that cycle.
- Wrap:
  - at IDX==cycle plus a step, IDX returns to 0 and the loop count increments.
  - if rep != all-ones and loop count reaches rep: IDX holds cycle, STOP=1, state STOPPED, no further strobes.
- States:
  - RUN: normal stepping.
  - PENDING: stepping continues, BUSY=1.
  - STOPPED: frozen.
- Request at cycle t (UPDATE=1):
  - IMMEDIATE: switch executes at t+1.
  - AT_WRAP: enter PENDING; switch executes in the cycle the wrap would occur. The wrapping step loads the new segment instead of index 0. In STOPPED, switch at t+1.
  - Reserved mode 3 (and mode 2 without macro): UPDATE ignored, state unchanged.
- Switch execution (single cycle): SEGMENT<=REQ; active regs loaded; IDX<=0; divider and loop counts<=0; STOP<=0; BUSY<=0; IDX_STROBE=1; state RUN.
- Requesting the currently active segment is legal: it restarts that segment and reloads its settings.
- UPDATE while PENDING: the new request replaces the pending one (segment and mode); the wrap/trigger condition is re-evaluated with the new mode.
- UPDATE coinciding with wrap in RUN, AT_WRAP mode: that wrap is not used; the switch waits for the next wrap.
- REQ_SEGMENT >= NUM_SEGMENTS: UPDATE ignored.
- RST mid-operation: immediate return to reset values; pending request discarded.

Optional Feature:
- Macro: SEGMENT_SEQUENCER_EXT_TRIG_EN.
- Defined:
  - TRIG port exists, double-flop synchronised.
  - Mode 2 enters PENDING; the switch executes on the cycle after a synchronised rising edge of TRIG.
  - Edges while not PENDING are ignored.
- Undefined: no TRIG port; mode 2 behaves as reserved.

Decomposition:
- Shared package: transition_mode_t enum (IMMEDIATE, AT_WRAP, EXT_TRIG); state enum (RUN, PENDING, STOPPED); REP_INFINITE constant.
- Sub-module: segment_index_counter. Holds the divider, index and loop counter. Has load, wrap and stop outputs. The parent holds the request FSM and segment muxing.

Test Plan:
- Reset then FREQ_DIV[0]=3, CYCLE[0]=3, REP infinite -> IDX 0,1,2,3,0 with strobes every 3 clocks; STOP=0.
- REP[0]=1, CYCLE[0]=2, FREQ_DIV[0]=1 -> IDX 0,1,2,0,1,2 then held at 2; STOP=1 on the cycle after the last step; no further strobes.
- Mode IMMEDIATE, REQ_SEGMENT=1 at IDX=5 -> next cycle SEGMENT=1, IDX=0, IDX_STROBE=1, BUSY=0.
- Mode AT_WRAP, REQ=1 at IDX=1 of CYCLE=7 -> BUSY=1 and IDX continues 2..7. A second UPDATE (REQ=0) mid-pending keeps BUSY=1; at the wrap, SEGMENT=0 restarts at IDX=0.
- REQ_SEGMENT=NUM_SEGMENTS, or mode 3 -> no change to SEGMENT/IDX/BUSY. RST asserted while PENDING -> all outputs 0 asynchronously.
- With SEGMENT_SEQUENCER_EXT_TRIG_EN: mode 2 REQ=1 -> BUSY=1 until TRIG rises. Switch executes on the cycle after the synchronised edge (3 clocks after TRIG). A TRIG pulse while not PENDING has no effect.
